alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 instr_valid  input  1  instruction word offered.
REQ-005 instr_ready  output  1  block accepts an instruction this cycle.
REQ-006 instr  input  32  ARM data-processing word: cond[31:28], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], operand2[11:0].
REQ-007 init_we / init_addr / init_data  input  1/4/32  register-bank preload port.
REQ-008 alu_a, alu_b  output  32  operand buses to the ALU.
REQ-009 alu_control  output  4  ALU op code.
REQ-010 alu_result  input  32  ALU combinational result.
REQ-011 alu_nzcv  input  4  ALU combinational flags.
REQ-012 wb_en / wb_addr / wb_data  output  1/4/32  register write-back strobe, index, data.
REQ-013 flags  output  4  architectural NZCV register.
REQ-014 und  output  1  one-cycle pulse on an unsupported opcode.

Function
REQ-015 The FSM SHALL have states IDLE, DECODE, EXECUTE and WRITEBACK.
REQ-016 instr_ready SHALL be 1 only in IDLE with init_we=0, so preload has priority over instruction accept.
REQ-017 In IDLE, instr_valid&instr_ready SHALL capture instr and go to DECODE.
REQ-018 In DECODE the block SHALL read Rn and Rm, decode the opcode, and evaluate cond against flags.
  - EQ/NE: Z. CS/CC: C. MI/PL: N. VS/VC: V.
  - HI: C&!Z. LS: !C|Z. GE: N==V. LT: N!=V. GT: !Z&(N==V). LE: Z|(N!=V).
  - AL (1110): pass. NV (1111): never.
REQ-019 Opcode mapping SHALL be:
  - ADD 0100 -> 0000 (S=0) or 0010 (S=1).
  - SUB 0010 -> 0001 (S=0) or 0011 (S=1).
  - CMP 1010 -> 0100.
  - AND 0000 -> 0111. ORR 1100 -> 1000. EOR 0001 -> 1001. MVN 1111 -> 1010.
REQ-020 Any other opcode SHALL pulse und for one cycle in DECODE and return to IDLE with no write-back and no flag change.
REQ-021 A failed condition SHALL return DECODE to IDLE with no write-back, no flag change and no und.
REQ-022 In EXECUTE the block SHALL drive alu_a=Rn, alu_b=operand2 value and alu_control, and register alu_result and alu_nzcv at the clock edge.
REQ-023 Operand2 SHALL be Rm[3:0] when I=0 (no register shift), or the immediate per REQ-031 when I=1.
REQ-024 In WRITEBACK, wb_en SHALL be 1 for exactly one cycle with wb_addr=Rd and wb_data=result, except for CMP (wb_en stays 0).
REQ-025 In WRITEBACK, flags SHALL load the registered nzcv when S=1 or the opcode is CMP; otherwise flags hold. The next state is IDLE.
REQ-026 Latency SHALL be four cycles from accept to write-back, with instr_ready=0 throughout. Back-to-back accept SHALL be possible on the cycle after WRITEBACK.
REQ-027 Write-back SHALL update the internal bank, so the following instruction observes the new value. R15 SHALL be treated as an ordinary register.
REQ-028 alu_a, alu_b and alu_control SHALL be 0 outside EXECUTE.

Reset
REQ-029 On rst (asynchronous, at any state including mid-instruction):
  - State SHALL go to IDLE and flags to 4'b0000.
  - wb_en and und SHALL go to 0, and all ALU buses to 0.
  - All 16 registers SHALL clear to 0; the in-flight instruction is discarded.
REQ-030 instr_ready SHALL be 1 in the first cycle after rst deasserts, provided init_we=0.

Configuration
REQ-031 Macro ALU_IMM_ROT_EN SHALL select the immediate format.
  - Defined: immediate = zero-extended imm8[7:0] rotated right by 2*rot[11:8].
  - Undefined: immediate = zero-extended imm8 and rot is ignored.

Structure
REQ-032 A shared package SHALL hold the ALU op-code constants, the ARM opcode and condition constants, and the FSM state enum.
REQ-033 The 16x32 register bank, with two async read ports, one sync write port and async clear, SHALL be sub-module alu_reg_bank. Write-back and preload share its write port, with preload only in IDLE.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Preload R1=5, R2=7, issue ADD R3,R1,R2 (0xE0813002) with a reference ALU -> wb_en one cycle in the fourth cycle after accept, wb_addr=3, wb_data=12, flags unchanged.
  - R1=R2=9, issue CMP R1,R2 (0xE1510002) -> no wb_en, flags Z=1; then ADDEQ R4,R1,#1 -> R4=10; ADDNE -> no write-back.
  - Issue opcode 1101 (MOV, unsupported) with AL -> und high exactly one cycle, back to IDLE, registers and flags unchanged.
  - ADD R5,R0,#0x01 with rot=4: with ALU_IMM_ROT_EN -> R5=0x01000000; without it -> R5=0x00000001.
  - Assert rst during EXECUTE -> no wb_en, flags=0, all registers 0, instr_ready=1 the cycle after release.
  - Hold instr_valid=1 with init_we=1 in IDLE -> instr_ready=0 and the preload is written; the instruction is accepted the cycle after init_we drops.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl_pkg                                           |
// | Description : Shared ALU op codes, ARM opcode/condition codes, FSM states  |
// |               and decode helpers for the ALU issue controller.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package alu_issue_ctrl_pkg;

   // ALU control codes driven on alu_control
   localparam logic [3:0] c_alu_add  = 4'b0000;
   localparam logic [3:0] c_alu_sub  = 4'b0001;
   localparam logic [3:0] c_alu_adds = 4'b0010;
   localparam logic [3:0] c_alu_subs = 4'b0011;
   localparam logic [3:0] c_alu_cmp  = 4'b0100;
   localparam logic [3:0] c_alu_and  = 4'b0111;
   localparam logic [3:0] c_alu_orr  = 4'b1000;
   localparam logic [3:0] c_alu_eor  = 4'b1001;
   localparam logic [3:0] c_alu_mvn  = 4'b1010;

   // ARM data-processing opcodes, instr[24:21]
   localparam logic [3:0] c_op_and = 4'b0000;
   localparam logic [3:0] c_op_eor = 4'b0001;
   localparam logic [3:0] c_op_sub = 4'b0010;
   localparam logic [3:0] c_op_add = 4'b0100;
   localparam logic [3:0] c_op_cmp = 4'b1010;
   localparam logic [3:0] c_op_orr = 4'b1100;
   localparam logic [3:0] c_op_mvn = 4'b1111;

   // ARM condition codes, instr[31:28]
   localparam logic [3:0] c_cond_eq = 4'b0000;
   localparam logic [3:0] c_cond_ne = 4'b0001;
   localparam logic [3:0] c_cond_cs = 4'b0010;
   localparam logic [3:0] c_cond_cc = 4'b0011;
   localparam logic [3:0] c_cond_mi = 4'b0100;
   localparam logic [3:0] c_cond_pl = 4'b0101;
   localparam logic [3:0] c_cond_vs = 4'b0110;
   localparam logic [3:0] c_cond_vc = 4'b0111;
   localparam logic [3:0] c_cond_hi = 4'b1000;
   localparam logic [3:0] c_cond_ls = 4'b1001;
   localparam logic [3:0] c_cond_ge = 4'b1010;
   localparam logic [3:0] c_cond_lt = 4'b1011;
   localparam logic [3:0] c_cond_gt = 4'b1100;
   localparam logic [3:0] c_cond_le = 4'b1101;
   localparam logic [3:0] c_cond_al = 4'b1110;
   localparam logic [3:0] c_cond_nv = 4'b1111;

   // Issue FSM states
   typedef logic [1:0] state_t;
   localparam logic [1:0] c_st_idle      = 2'd0;
   localparam logic [1:0] c_st_decode    = 2'd1;
   localparam logic [1:0] c_st_execute   = 2'd2;
   localparam logic [1:0] c_st_writeback = 2'd3;

   typedef struct packed {
      logic       supported;
      logic       is_cmp;
      logic [3:0] alu_ctl;
   } op_dec_t;

   function automatic op_dec_t decode_op(input logic [3:0] opcode, input logic s_bit);
      op_dec_t d;
      d.supported = 1'b1;
      d.is_cmp    = 1'b0;
      d.alu_ctl   = c_alu_add;
      case (opcode)
         c_op_add: d.alu_ctl = s_bit ? c_alu_adds : c_alu_add;
         c_op_sub: d.alu_ctl = s_bit ? c_alu_subs : c_alu_sub;
         c_op_cmp: begin
            d.alu_ctl = c_alu_cmp;
            d.is_cmp  = 1'b1;
         end
         c_op_and: d.alu_ctl = c_alu_and;
         c_op_orr: d.alu_ctl = c_alu_orr;
         c_op_eor: d.alu_ctl = c_alu_eor;
         c_op_mvn: d.alu_ctl = c_alu_mvn;
         default:  d.supported = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, pass;
      {n, z, c, v} = nzcv;
      case (cond)
         c_cond_eq: pass = z;
         c_cond_ne: pass = !z;
         c_cond_cs: pass = c;
         c_cond_cc: pass = !c;
         c_cond_mi: pass = n;
         c_cond_pl: pass = !n;
         c_cond_vs: pass = v;
         c_cond_vc: pass = !v;
         c_cond_hi: pass = c && !z;
         c_cond_ls: pass = !c || z;
         c_cond_ge: pass = (n == v);
         c_cond_lt: pass = (n != v);
         c_cond_gt: pass = !z && (n == v);
         c_cond_le: pass = z || (n != v);
         c_cond_al: pass = 1'b1;
         default:   pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_reg_bank                                                 |
// | Description : 16x32 register bank, two async read ports, one sync write   |
// |               port, asynchronous clear.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_reg_bank (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we,
   input  logic [3:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_raddr_a,
   input  logic [3:0]  i_raddr_b,
   output logic [31:0] o_rdata_a,
   output logic [31:0] o_rdata_b
);

   logic [31:0] r_regs [16];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata_a = r_regs[i_raddr_a];
   assign o_rdata_b = r_regs[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issue_ctrl                                               |
// | Description : Four-state issue controller for ARM data-processing words    |
// |               driving an external combinational ALU. Macro ALU_IMM_ROT_EN  |
// |               enables the rotated-immediate operand format.                |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl
   import alu_issue_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic        init_we,
   input  logic [3:0]  init_addr,
   input  logic [31:0] init_data,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_control,
   input  logic [31:0] alu_result,
   input  logic [3:0]  alu_nzcv,
   output logic        wb_en,
   output logic [3:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic [3:0]  flags,
   output logic        und
);

   state_t      r_state;
   logic [31:0] r_instr;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [31:0] r_result;
   logic [3:0]  r_alu_ctl;
   logic [3:0]  r_nzcv;
   logic [3:0]  r_flags;
   logic        r_wb_req;
   logic        r_flag_upd;

   logic [31:0] w_rd_a;
   logic [31:0] w_rd_b;
   logic [31:0] w_imm;
   op_dec_t     w_dec;
   logic        w_pass;
   logic        w_accept;
   logic        w_go_exec;
   logic        w_bank_we;
   logic [3:0]  w_bank_waddr;
   logic [31:0] w_bank_wdata;
   logic        w_unused_bits;

   assign w_dec     = decode_op(r_instr[24:21], r_instr[20]);
   assign w_pass    = cond_pass(r_instr[31:28], r_flags);
   assign w_go_exec = w_pass && w_dec.supported;

   assign instr_ready = (r_state == c_st_idle) && !init_we;
   assign w_accept    = instr_valid && instr_ready;

`ifdef ALU_IMM_ROT_EN
   logic [31:0] w_imm_raw;
   logic [4:0]  w_rot_amt;
   assign w_imm_raw = {24'b0, r_instr[7:0]};
   assign w_rot_amt = {r_instr[11:8], 1'b0};
   // Rotate right; a shift by 32 yields zero, which covers the rot=0 case.
   assign w_imm = (w_imm_raw >> w_rot_amt) | (w_imm_raw << (6'd32 - {1'b0, w_rot_amt}));
   assign w_unused_bits = ^r_instr[27:26];
`else
   assign w_imm = {24'b0, r_instr[7:0]};
   assign w_unused_bits = ^{r_instr[27:26], r_instr[11:8]};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_instr    <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_result   <= '0;
         r_alu_ctl  <= '0;
         r_nzcv     <= '0;
         r_flags    <= '0;
         r_wb_req   <= 1'b0;
         r_flag_upd <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_instr <= instr;
                  r_state <= c_st_decode;
               end
            end
            c_st_decode: begin
               // Failed condition or unsupported opcode drops the instruction here.
               if (w_go_exec) begin
                  r_op_a     <= w_rd_a;
                  r_op_b     <= r_instr[25] ? w_imm : w_rd_b;
                  r_alu_ctl  <= w_dec.alu_ctl;
                  r_wb_req   <= !w_dec.is_cmp;
                  r_flag_upd <= r_instr[20] || w_dec.is_cmp;
                  r_state    <= c_st_execute;
               end else begin
                  r_state <= c_st_idle;
               end
            end
            c_st_execute: begin
               r_result <= alu_result;
               r_nzcv   <= alu_nzcv;
               r_state  <= c_st_writeback;
            end
            c_st_writeback: begin
               if (r_flag_upd) begin
                  r_flags <= r_nzcv;
               end
               r_state <= c_st_idle;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign alu_a       = (r_state == c_st_execute) ? r_op_a    : '0;
   assign alu_b       = (r_state == c_st_execute) ? r_op_b    : '0;
   assign alu_control = (r_state == c_st_execute) ? r_alu_ctl : '0;

   assign wb_en   = (r_state == c_st_writeback) && r_wb_req;
   assign wb_addr = r_instr[15:12];
   assign wb_data = r_result;
   assign flags   = r_flags;
   assign und     = (r_state == c_st_decode) && w_pass && !w_dec.supported;

   // Write-back and preload share the bank write port; preload only in IDLE.
   assign w_bank_we    = wb_en || ((r_state == c_st_idle) && init_we);
   assign w_bank_waddr = wb_en ? r_instr[15:12] : init_addr;
   assign w_bank_wdata = wb_en ? r_result       : init_data;

   alu_reg_bank u_reg_bank (
      .clk       (clk),
      .rst       (rst),
      .i_we      (w_bank_we),
      .i_waddr   (w_bank_waddr),
      .i_wdata   (w_bank_wdata),
      .i_raddr_a (r_instr[19:16]),
      .i_raddr_b (r_instr[3:0]),
      .o_rdata_a (w_rd_a),
      .o_rdata_b (w_rd_b)
   );

endmodule
`default_nettype wire
